// File: rtl/regfile_writeback_arbiter.sv
// WB-stage register file writer: merges single-cycle ALU results with variable-latency
// load responses queued in a small FIFO, and publishes a pending-destination mask.
module regfile_writeback_arbiter #(
  parameter int unsigned LOAD_DEPTH = 4,
  parameter int unsigned CW         = $clog2(LOAD_DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          alu_valid,
  input  logic [4:0]    alu_rd,
  input  logic [31:0]   alu_data,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [4:0]    load_rd,
  input  logic [2:0]    load_funct3,
  input  logic [1:0]    load_offset,
  input  logic [31:0]   load_rdata,
  output logic          write_enable,
  output logic [4:0]    write_addr,
  output logic [31:0]   write_data,
  output logic [31:0]   pending_mask,
  output logic [CW-1:0] load_count,
  output logic          drop_error
);

  localparam int unsigned PW = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t          fifo_q [LOAD_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            we_q, we_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            drop_q, drop_d;

  logic            alu_take;
  logic            push;
  logic            pop;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [31:0]     load_fmt;
  logic [PW-1:0]   rel;

  assign load_ready = (count_q < CW'(LOAD_DEPTH));
  assign alu_take   = alu_valid && (alu_rd != 5'd0);
  // Loads to x0 complete the handshake but are never stored.
  assign push       = load_valid && load_ready && (load_rd != 5'd0);
  assign pop        = !alu_take && (count_q != '0);

  always_comb begin
    byte_sel = load_rdata[7:0];
    unique case (load_offset)
      2'd0: byte_sel = load_rdata[7:0];
      2'd1: byte_sel = load_rdata[15:8];
      2'd2: byte_sel = load_rdata[23:16];
      2'd3: byte_sel = load_rdata[31:24];
      default: byte_sel = load_rdata[7:0];
    endcase
    half_sel = load_offset[1] ? load_rdata[31:16] : load_rdata[15:0];
    case (load_funct3)
      3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_fmt = {24'd0, byte_sel};
      3'b101:  load_fmt = {16'd0, half_sel};
      default: load_fmt = load_rdata;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    drop_d   = drop_q | (load_valid & ~load_ready);

    if (alu_take) begin
      we_d    = 1'b1;
      waddr_d = alu_rd;
      wdata_d = alu_data;
    end else if (pop) begin
      we_d     = 1'b1;
      waddr_d  = fifo_q[rd_ptr_q].rd;
      wdata_d  = fifo_q[rd_ptr_q].data;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{rd: load_rd, data: load_fmt};
    end
  end

  always_comb begin
    pending_mask = '0;
    rel          = '0;
    for (int unsigned i = 0; i < LOAD_DEPTH; i++) begin
      rel = PW'(i) - rd_ptr_q;
      if (CW'(rel) < count_q) begin
        pending_mask[fifo_q[i].rd] = 1'b1;
      end
    end
    if (we_q) begin
      pending_mask[waddr_q] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  assign write_enable = we_q;
  assign write_addr   = waddr_q;
  assign write_data   = wdata_q;
  assign load_count   = count_q;
  assign drop_error   = drop_q;

endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
- Writer side of the register file write port (write_enable / write_addr / write_data) in the 5-stage pipeline's WB stage.
- Merges single-cycle ALU results with load responses from data memory, which arrive with variable latency.
- Aligns and sign-extends load data, queues loads in a small FIFO, and never writes x0.
- Publishes a pending-destination mask so hazard logic can stall readers of in-flight registers.

Parameters:
- LOAD_DEPTH, 4, load FIFO entries (power of 2, >= 2)
- CW, $clog2(LOAD_DEPTH+1), width of load_count

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle (no backpressure)
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- load_valid  in  1  load response valid
- load_ready  out  1  FIFO can accept a load
- load_rd  in  5  load destination register
- load_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- load_offset  in  2  byte address[1:0] of the load
- load_rdata  in  32  raw aligned memory word
- write_enable  out  1  register file write enable
- write_addr  out  5  register file write address
- write_data  out  32  register file write data
- pending_mask  out  32  bit i = write to xi still outstanding
- load_count  out  CW  FIFO occupancy
- drop_error  out  1  sticky: load_valid seen while load_ready=0

Behaviour:
- Reset (async assert, sync deassert): write_enable=0, write_addr=0, write_data=0, FIFO empty, load_count=0, drop_error=0, pending_mask=0. Reset mid-operation discards all queued loads.
- load_ready = (load_count < LOAD_DEPTH), combinational from state only. A pop in the same cycle does not free a slot.
- Load accept: load_valid && load_ready at an edge. Data is formatted before the push:
  - LB/LBU select byte load_offset; LH/LHU select halfword load_offset[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW and the undefined funct3 codes (011, 110, 111) pass the whole word.
- A load with load_rd=0 completes the handshake but is not enqueued. load_count is unchanged.
- load_valid && !load_ready: the load is dropped and drop_error sets to 1. It clears only on reset.
- Port selection each cycle:
  - If alu_valid && alu_rd!=0, the ALU result is registered onto the write port and the FIFO is not popped.
  - Otherwise, if the FIFO is non-empty, the head is popped and registered onto the write port.
  - Otherwise write_enable=0 next cycle, and write_addr/write_data hold their values.
- alu_valid with alu_rd=0 is ignored and does not block a FIFO pop.
- Latency:
  - ALU sampled at edge E: write_enable=1 after E, regfile commits at E+1.
  - Load accepted at edge E into an empty FIFO with no ALU competition: write_enable=1 after E+1.
- Push and pop in the same cycle: load_count is unchanged. FIFO pointers wrap modulo LOAD_DEPTH.
- load_count = number of valid FIFO entries, 0..LOAD_DEPTH.
- pending_mask is combinational from state:
  - bit i = 1 if any FIFO entry has rd=i, or (write_enable && write_addr==i).
  - bit 0 is always 0.
- Ordering: the issue logic must stall any instruction whose rd is set in pending_mask. A WAW between the ALU path and a queued load is undefined.

Test Plan:
- Reset with FIFO holding 2 loads -> after reset_n low: load_count=0, write_enable=0, pending_mask=0, load_ready=1.
- alu_valid, rd=5, data=0x11111111 for one cycle -> next cycle write_enable=1, addr=5, data=0x11111111, pending_mask=0x20; cycle after that write_enable=0.
- Load rdata=0x80FF7F01, rd=7, one load per funct3/offset pair -> written values:
  - LB off0=0x00000001, LB off3=0xFFFFFF80, LBU off3=0x00000080
  - LH off0=0x00007F01, LH off2=0xFFFF80FF, LHU off2=0x000080FF
  - LW=0x80FF7F01
- ALU rd=3 on every cycle for 6 cycles while 4 loads are pushed (rd=10..13) -> load_count reaches 4 and load_ready=0; the 5th load_valid sets drop_error=1; after the ALU stops, x10..x13 are written in order on consecutive cycles.
- Load rd=0 and ALU rd=0 -> no write_enable, load_count unchanged, pending_mask bit0=0; a queued load rd=9 pops in the same cycle as the ALU rd=0.
- Simultaneous push and pop with load_count=2 -> load_count stays 2; a pointer wrap after 9 sequential loads (rd=1..9) keeps write order 1..9.
